// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
// Checksum width applies only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: gathers four stream bytes into a little-endian word.
// word_valid pulses combinationally with the fourth accepted byte.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);

  logic [CW-1:0] r_cnt;
  logic [23:0]   r_sh;

  // byte counter and shift register; held while no byte is accepted
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
      r_sh  <= {i_byte, r_sh[23:8]};
    end
  end

  assign o_word_valid = i_en && (r_cnt == LAST);
  assign o_word       = {i_byte, r_sh};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream programmer for the instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int LW = LEN_BYTES * 8;

  state_t                r_state;
  state_t                w_next;
  state_t                w_fin;
  logic [LW-1:0]         r_len;
  logic [LW-1:0]         w_nlen;
  logic [ADDR_WIDTH:0]   r_wcnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;
  logic                  w_ready;
  logic                  w_acc;
  logic                  w_start;
  logic                  w_too_big;
  logic                  w_last;
  logic                  w_byte_en;
  logic                  w_word_valid;
  logic [31:0]           w_word;

  assign w_ready = r_state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  assign w_acc   = in_valid && w_ready;
  assign w_start = start &&
                   (r_state inside {S_IDLE, S_DONE, S_ERR});

  assign w_nlen    = {in_data, r_len[7:0]};
  assign w_too_big = 32'(w_nlen) > DEPTH;
  assign w_last    = (16'(r_wcnt) + 16'd1) == r_len;
  assign w_byte_en = w_acc && (r_state == S_DATA);

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign w_fin = S_CSUM;

  logic [CSUM_W-1:0] r_csum;

  // running XOR of every accepted data byte
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_csum <= '0;
    end else if (w_byte_en) begin
      r_csum <= r_csum ^ in_data;
    end
  end
`else
  assign w_fin = S_DONE;
`endif

  imem_word_packer u_pack (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_start),
    .i_en         (w_byte_en),
    .i_byte       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_start) w_next = S_LEN0;
      end
      S_LEN0: begin
        if (w_acc) w_next = S_LEN1;
      end
      S_LEN1: begin
        if (w_acc) begin
          if (w_too_big)          w_next = S_ERR;
          else if (w_nlen == '0)  w_next = w_fin;
          else                    w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_word_valid && w_last) w_next = w_fin;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_acc) begin
          w_next = (in_data == r_csum) ? S_DONE : S_ERR;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // length capture, word counter and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len   <= '0;
      r_wcnt  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_word_valid;
      if (w_start) begin
        r_len  <= '0;
        r_wcnt <= '0;
      end
      if (w_acc && r_state == S_LEN0) r_len[7:0]  <= in_data;
      if (w_acc && r_state == S_LEN1) r_len[15:8] <= in_data;
      if (w_word_valid) begin
        r_waddr <= r_wcnt[ADDR_WIDTH-1:0];
        r_wdata <= w_word;
        r_wcnt  <= r_wcnt + 1'b1;
      end
    end
  end

  assign in_ready = w_ready;
  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign busy     = w_ready;
  assign done     = (r_state == S_DONE);
  assign error    = (r_state == S_ERR);
  assign cpu_hold = w_ready || (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven frames with a write scoreboard for imem_loader.
// Checksum paths are exercised when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_hold;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } exp_t;

  typedef struct {
    logic [7:0]  b[4];
    logic [31:0] w;
  } wvec_t;

  typedef struct {
    logic [15:0] n;
    logic        exp_err;
  } lvec_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] wlist[$];
  wvec_t       tbl[4];
  lvec_t       ltbl[4];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_we  = 0;
  int          we0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // write scoreboard
  always @(negedge clk) begin
    if (we) begin
      n_we++;
      if (q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("waddr", 32'(waddr), 32'(e.a));
        chk("wdata", wdata, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_frame(input bit gap, input bit mid_start,
                            input bit bad_csum);
    logic [7:0]  xs;
    logic [15:0] n;
    xs = 8'h00;
    n  = 16'(wlist.size());
    do_start();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < wlist.size(); i++) begin
      logic [31:0] w;
      w = wlist[i];
      q.push_back('{a: AW'(i), d: w});
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = w[8*k +: 8];
        send_byte(b);
        xs = xs ^ b;
        if (gap && k == 1) begin
          if (mid_start && i == 1) start = 1'b1;
          repeat (3) begin
            tick();
            start = 1'b0;
          end
          if (mid_start && i == 1) chk("busy_after_start", 32'(busy), 32'd1);
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? 8'h00 : xs);
`else
    if (bad_csum) chk("no_csum_build", 32'd0, 32'd0 + 32'(xs == xs) - 32'd1);
`endif
  endtask

  task automatic load_tbl();
    wlist.delete();
    for (int i = 0; i < 4; i++) wlist.push_back(tbl[i].w);
  endtask

  initial begin
    tbl[0].b = '{8'h13, 8'h01, 8'h50, 8'h00}; tbl[0].w = 32'h00500113;
    tbl[1].b = '{8'h93, 8'h01, 8'hA0, 8'h00}; tbl[1].w = 32'h00A00193;
    tbl[2].b = '{8'h33, 8'h02, 8'h31, 8'h00}; tbl[2].w = 32'h00310233;
    tbl[3].b = '{8'h23, 8'h26, 8'hF0, 8'h00}; tbl[3].w = 32'h00F02623;
    ltbl[0] = '{n: 16'd1025, exp_err: 1'b1};
    ltbl[1] = '{n: 16'hFFFF, exp_err: 1'b1};
    ltbl[2] = '{n: 16'h8000, exp_err: 1'b1};
    ltbl[3] = '{n: 16'd0,    exp_err: 1'b0};

    // reset state
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we",       32'(we),       32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_error",    32'(error),    32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_waddr",    32'(waddr),    32'd0);
    chk("rst_wdata",    wdata,         32'd0);
    reset = 1'b0;
    tick();

    // stream bytes are taken from the table, not from the word field
    wlist.delete();
    for (int i = 0; i < 4; i++) begin
      wlist.push_back({tbl[i].b[3], tbl[i].b[2], tbl[i].b[1], tbl[i].b[0]});
    end
    we0 = n_we;
    send_frame(1'b0, 1'b0, 1'b0);
    chk("basic_done",     32'(done),     32'd1);
    chk("basic_busy",     32'(busy),     32'd0);
    chk("basic_cpu_hold", 32'(cpu_hold), 32'd0);
    tick();
    chk("basic_we_count", 32'(n_we - we0), 32'd4);

    // length boundary table
    for (int i = 0; i < 4; i++) begin
      we0 = n_we;
      do_start();
      chk("len_busy", 32'(busy), 32'd1);
      send_byte(ltbl[i].n[7:0]);
      send_byte(ltbl[i].n[15:8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!ltbl[i].exp_err) begin
        chk("len0_csum_busy", 32'(busy), 32'd1);
        send_byte(8'h00);
      end
`endif
      chk("len_error",    32'(error),    32'(ltbl[i].exp_err));
      chk("len_done",     32'(done),     32'(!ltbl[i].exp_err));
      chk("len_cpu_hold", 32'(cpu_hold), 32'(ltbl[i].exp_err));
      repeat (2) tick();
      chk("len_no_we", 32'(n_we - we0), 32'd0);
    end

    // gaps inside each word plus a start pulse during DATA
    load_tbl();
    we0 = n_we;
    send_frame(1'b1, 1'b1, 1'b0);
    chk("gap_done",  32'(done),  32'd1);
    chk("gap_error", 32'(error), 32'd0);
    tick();
    chk("gap_we_count", 32'(n_we - we0), 32'd4);

    // reset after six data bytes
    we0 = n_we;
    do_start();
    send_byte(8'h04);
    send_byte(8'h00);
    q.push_back('{a: '0, d: tbl[0].w});
    for (int k = 0; k < 4; k++) send_byte(tbl[0].b[k]);
    send_byte(tbl[1].b[0]);
    send_byte(tbl[1].b[1]);
    reset = 1'b1;
    tick();
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_hold",  32'(cpu_hold), 32'd0);
    chk("mid_rst_done",  32'(done | error), 32'd0);
    chk("mid_rst_we",    32'(we),       32'd0);
    chk("mid_rst_waddr", 32'(waddr),    32'd0);
    chk("mid_rst_wdata", wdata,         32'd0);
    reset = 1'b0;
    repeat (4) tick();
    chk("mid_rst_we_count", 32'(n_we - we0), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // wrong checksum
    load_tbl();
    send_frame(1'b0, 1'b0, 1'b1);
    chk("bad_csum_error", 32'(error),    32'd1);
    chk("bad_csum_done",  32'(done),     32'd0);
    chk("bad_csum_hold",  32'(cpu_hold), 32'd1);
`endif

    // full-depth frame: last address all-ones, no wrap
    wlist.delete();
    for (int i = 0; i < (1 << AW); i++) begin
      wlist.push_back(32'(i) * 32'h9E3779B1 + 32'h1234);
    end
    we0 = n_we;
    send_frame(1'b0, 1'b0, 1'b0);
    chk("full_done",  32'(done),  32'd1);
    chk("full_waddr", 32'(waddr), 32'(1 << AW) - 32'd1);
    tick();
    chk("full_we_count", 32'(n_we - we0), 32'(1 << AW));

    repeat (3) tick();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
